rv32i_data_mem: RTL and testbench

Word-organised data memory that acts as the responder to the rv32i_cpu data-side load/store port.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states.
- Returns a response (read data plus error flag) over a second valid/ready handshake.
- Sits on the CPU data bus at a fixed base address; it is the device the core-level testbench instantiates beside rv32i_cpu.

---
 rtl/rv32i_data_mem_if.sv | 24 ++
 rtl/rv32i_data_mem.sv | 124 ++++++++++++
 tb/tb_rv32i_data_mem.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_data_mem_if.sv
// Load/store bus between the rv32i_cpu data port and its data memory.
// Carries a request channel and a response channel, each with a valid/ready handshake.
interface rv32i_data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv32i_data_mem.sv
// Word-organised data memory responding to the rv32i_cpu load/store port.
// Takes one request at a time, waits WAIT_CYCLES, then returns read data and an error flag.
module rv32i_data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  rv32i_data_mem_if.slave bus
);
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]     offset, cur_word, new_word;
  logic [IdxW-1:0] idx;
  logic            err, accept, exec;
  logic            unused_offset_lsb;

  assign accept            = (state_q == StIdle) && bus.req_valid && req_ready_q;
  assign exec              = (state_q == StWait) && (cnt_q == 4'd0);
  assign offset            = addr_q - BASE_ADDR;
  assign idx               = offset[IdxW+1:2];
  assign unused_offset_lsb = ^offset[1:0];
  // Base is aligned to the array size, so once addr >= base any bit above the index is out of range
  assign err      = (addr_q < BASE_ADDR) || (offset[31:IdxW+2] != '0) || (be_q == 4'h0);
  assign cur_word = mem[idx];

  always_comb begin
    new_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) new_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err;
          rsp_rdata_d = err ? 32'h0 : (we_q ? new_word : cur_word);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == StIdle);
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
    end
  end

  // Array is deliberately not reset; a store executed before a reset survives it
  always_ff @(posedge clk) begin
    if (exec && we_q && !err) mem[idx] <= new_word;
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_rv32i_data_mem.sv
// Scoreboarded bench for rv32i_data_mem: instance A (WAIT_CYCLES=1) with a reference model
// and response monitor, instance B (WAIT_CYCLES=4) for latency and reset-mid-wait behaviour.
module tb_rv32i_data_mem;
  localparam logic [31:0] Base   = 32'h0001_0000;
  localparam int unsigned DepthA = 1024;
  localparam int unsigned DepthB = 16;

  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;
  always #5 clk = ~clk;

  rv32i_data_mem_if bus_a ();
  rv32i_data_mem_if bus_b ();

  rv32i_data_mem #(.DEPTH_WORDS(DepthA), .BASE_ADDR(Base), .WAIT_CYCLES(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a)
  );

  rv32i_data_mem #(.DEPTH_WORDS(DepthB), .BASE_ADDR(Base), .WAIT_CYCLES(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_q [$];          // {err, rdata}
  logic [31:0] mem_m [int unsigned];

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  function automatic void note_timeout(string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  // Reference model: word array indexed by (addr-base)/4, lanes merged by byte enable
  function automatic logic [32:0] model(logic we, logic [31:0] addr, logic [31:0] wdata,
                                        logic [3:0] be);
    longint unsigned a = 64'(addr);
    longint unsigned hi = 64'(Base) + 64'(4 * DepthA);
    int unsigned idx;
    logic [31:0] w;
    if (a < 64'(Base) || a >= hi || be == 4'h0) return {1'b1, 32'h0};
    idx = (addr - Base) / 4;
    w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
    if (we) begin
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
      mem_m[idx] = w;
    end
    return {1'b0, w};
  endfunction

  // Response monitor for instance A
  always @(negedge clk) begin
    if (rst_n_a && bus_a.rsp_valid && bus_a.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got err=%b rdata=%h with no request outstanding",
                 bus_a.rsp_err, bus_a.rsp_rdata);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_a", 64'({bus_a.rsp_err, bus_a.rsp_rdata}), 64'(e));
      end
    end
  end

  task automatic send_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    int n;
    exp_q.push_back(model(we, addr, wdata, be));
    @(posedge clk); #1;
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = we;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    bus_a.req_be    = be;
    n = 0;
    while (!bus_a.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus_a.req_ready) begin
      note_timeout("req_ready_a");
      bus_a.req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus_a.req_valid = 1'b0;
    end
  endtask

  task automatic drain_a();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) note_timeout("drain_a");
  endtask

  task automatic send_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    rd  = 32'h0;
    er  = 1'b1;
    lat = -1;
    @(posedge clk); #1;
    bus_b.req_valid = 1'b1;
    bus_b.req_we    = we;
    bus_b.req_addr  = addr;
    bus_b.req_wdata = wdata;
    bus_b.req_be    = be;
    n = 0;
    while (!bus_b.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus_b.req_ready) begin
      note_timeout("req_ready_b");
      bus_b.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus_b.req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_b.rsp_valid && lat < 50);
    if (bus_b.rsp_valid) begin
      rd = bus_b.rsp_rdata;
      er = bus_b.rsp_err;
    end else begin
      note_timeout("rsp_valid_b");
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic        seen;

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
    bus_a.req_wdata = '0;   bus_a.req_be = '0;   bus_a.rsp_ready = 1'b1;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
    bus_b.req_wdata = '0;   bus_b.req_be = '0;   bus_b.rsp_ready = 1'b1;

    // Reset: outputs held low throughout
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("reset_outputs", 64'({bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err,
                                bus_a.rsp_rdata}), 64'h0);
    end
    rst_n_a = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_reset", 64'(bus_a.req_ready), 64'h1);

    // Full-word store with latency check, then load back
    send_a(1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1;
    chk("latency_early", 64'(bus_a.rsp_valid), 64'h0);
    @(posedge clk); #1;
    chk("latency_accept_plus_2", 64'(bus_a.rsp_valid), 64'h1);
    drain_a();
    send_a(1'b0, 32'h0001_0010, 32'h0, 4'hF);

    // Byte-lane merge
    send_a(1'b1, 32'h0001_0020, 32'h1122_3344, 4'hF);
    send_a(1'b1, 32'h0001_0020, 32'hAA55_66BB, 4'b1001);
    send_a(1'b0, 32'h0001_0020, 32'h0, 4'hF);
    drain_a();
    chk("byte_lane_model", 64'(mem_m[8]), 64'hAA22_33BB);

    // Preload a 16-word window for the later random phase
    for (int i = 0; i < 16; i++) send_a(1'b1, Base + 32'(4 * i), $urandom, 4'hF);

    // Error cases, each followed by a load proving memory was not disturbed
    send_a(1'b0, 32'h0000_FFFC, 32'h0, 4'hF);
    send_a(1'b1, Base + 32'(4 * DepthA), 32'hCAFE_F00D, 4'hF);
    send_a(1'b0, Base, 32'h0, 4'hF);
    send_a(1'b1, 32'h0001_0010, 32'h0BAD_0BAD, 4'h0);
    send_a(1'b0, 32'h0001_0010, 32'h0, 4'hF);
    send_a(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF);
    drain_a();

    // Backpressure: response held for 5 cycles, competing request must be ignored
    @(posedge clk); #1;
    bus_a.rsp_ready = 1'b0;
    send_a(1'b0, 32'h0001_0010, 32'h0, 4'hF);
    n = 0;
    while (!bus_a.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus_a.rsp_valid) note_timeout("rsp_valid_bp");
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = 1'b1;
    bus_a.req_addr  = 32'h0001_0014;
    bus_a.req_wdata = 32'h7777_7777;
    bus_a.req_be    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 64'(bus_a.rsp_valid), 64'h1);
      if (exp_q.size() != 0) chk("bp_rsp_stable", 64'({bus_a.rsp_err, bus_a.rsp_rdata}),
                                 64'(exp_q[0]));
      chk("bp_req_ready", 64'(bus_a.req_ready), 64'h0);
    end
    bus_a.rsp_ready = 1'b1;
    bus_a.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_released_valid", 64'(bus_a.rsp_valid), 64'h0);
    chk("bp_released_ready", 64'(bus_a.req_ready), 64'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_no_late_rsp", 64'(bus_a.rsp_valid), 64'h0);

    // Randomised traffic over the preloaded window, with some invalid requests
    for (int i = 0; i < 60; i++) begin
      logic [31:0] addr;
      logic [3:0]  be;
      addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h8000_0000)
                                         : Base + 32'(4 * $urandom_range(0, 15))
                                                + 32'($urandom_range(0, 3));
      be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      send_a(1'($urandom_range(0, 1)), addr, $urandom, be);
    end
    drain_a();

    // Instance B: latency with four wait states, then reset in the middle of a wait
    rst_n_b = 1'b1;
    send_b(1'b1, Base + 32'h8, 32'h1234_5678, 4'hF, rd, er, lat);
    chk("b_store_rsp", 64'({er, rd}), 64'({1'b0, 32'h1234_5678}));
    chk("b_latency", 64'(lat), 64'd5);

    @(posedge clk); #1;
    bus_b.req_valid = 1'b1;
    bus_b.req_we    = 1'b1;
    bus_b.req_addr  = Base + 32'h8;
    bus_b.req_wdata = 32'h5555_5555;
    bus_b.req_be    = 4'hF;
    n = 0;
    while (!bus_b.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus_b.req_ready) note_timeout("req_ready_b_rst");
    @(posedge clk); #1;
    bus_b.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_b = 1'b0;
    #1;
    chk("b_reset_outputs", 64'({bus_b.req_ready, bus_b.rsp_valid}), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n_b = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus_b.rsp_valid) seen = 1'b1;
    end
    chk("b_no_rsp_after_reset", 64'(seen), 64'h0);
    chk("b_ready_after_reset", 64'(bus_b.req_ready), 64'h1);
    send_b(1'b0, Base + 32'h8, 32'h0, 4'hF, rd, er, lat);
    chk("b_store_dropped", 64'({er, rd}), 64'({1'b0, 32'h1234_5678}));

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
